seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 172 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment display scanner.
// Each digit gets a slot of REFRESH_DIV clocks; the first DEAD_CYCLES clocks of every slot
// keep all anodes off to avoid ghosting. New values are captured into a shadow register on
// load and promoted to the display register only at a frame boundary, so a frame never
// shows a mix of old and new digits.
// Optional macro SEG7_HEX_EN: decode codes 10..15 as A,b,C,d,E,F instead of blanking them.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lzb_en,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    slot_tick
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      cnt_wrap, frame_end;

  logic [4*NUM_DIGITS-1:0]   shadow_value_q;
  logic [NUM_DIGITS-1:0]     shadow_dp_q;
  logic                      shadow_lzb_q;
  logic [4*NUM_DIGITS-1:0]   disp_value_q;
  logic [NUM_DIGITS-1:0]     disp_dp_q;
  logic                      disp_lzb_q;

  logic [3:0]                sel_code;
  logic                      sel_dp, sel_blank, upper_zero, dead;
  logic [NUM_DIGITS-1:0]     an_d;
  logic [6:0]                seg_d;
  logic                      dp_d;

  logic [NUM_DIGITS-1:0]     an_q;
  logic [6:0]                seg_q;
  logic                      dp_q;
  logic                      tick_q;

  // Active-high glyph {a,b,c,d,e,f,g}; all-zero means blank.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'b1111110;
      4'd1:    g = 7'b0110000;
      4'd2:    g = 7'b1101101;
      4'd3:    g = 7'b1111001;
      4'd4:    g = 7'b0110011;
      4'd5:    g = 7'b1011011;
      4'd6:    g = 7'b1011111;
      4'd7:    g = 7'b1110000;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1111011;
`ifdef SEG7_HEX_EN
      4'd10:   g = 7'b1110111;
      4'd11:   g = 7'b0011111;
      4'd12:   g = 7'b1001110;
      4'd13:   g = 7'b0111101;
      4'd14:   g = 7'b1001111;
      4'd15:   g = 7'b1000111;
`endif
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // Refresh counter and digit index next state.
  always_comb begin
    cnt_wrap  = (cnt_q == CNT_MAX);
    frame_end = cnt_wrap && (idx_q == IDX_MAX);
    cnt_d     = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Select the current digit and work out leading-zero blanking from the top down.
  always_comb begin
    sel_code   = 4'd0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (disp_value_q[4*k +: 4] == 4'd0);
      if (IDX_W'(k) == idx_q) begin
        sel_code  = disp_value_q[4*k +: 4];
        sel_dp    = disp_dp_q[k];
        sel_blank = disp_lzb_q && upper_zero && (k != 0);
      end
    end
  end

  // Next values of the registered display outputs.
  always_comb begin
    dead = (cnt_q < CNT_DEAD);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_d[k] = dead || (IDX_W'(k) != idx_q);
    end
    seg_d = sel_blank ? 7'b1111111 : ~glyph(sel_code);
    dp_d  = dead || !sel_dp;
  end

  // Scan state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= 7'b1111111;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= cnt_wrap;
    end
  end

  // Shadow capture; last load wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_lzb_q   <= 1'b0;
    end else if (load) begin
      shadow_value_q <= value;
      shadow_dp_q    <= dp;
      shadow_lzb_q   <= lzb_en;
    end
  end

  // Display register: promote at frame boundary; a coincident load bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_value_q <= '0;
      disp_dp_q    <= '0;
      disp_lzb_q   <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        disp_value_q <= value;
        disp_dp_q    <= dp;
        disp_lzb_q   <= lzb_en;
      end else begin
        disp_value_q <= shadow_value_q;
        disp_dp_q    <= shadow_dp_q;
        disp_lzb_q   <= shadow_lzb_q;
      end
    end
  end

  assign an_n      = an_q;
  assign seg_n     = seg_q;
  assign dp_n      = dp_q;
  assign slot_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.
// Stimulus queues the expected lit state of each digit slot; the monitor pops one entry
// whenever a digit lights up and checks it for every lit cycle of that slot.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lzb_en;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        slot_tick;

  int checks = 0;
  int errors = 0;
  int n = 0;  // rising edges since the last reset release

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [6:0] Z0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] BL = 7'b1111111;
`ifdef SEG7_HEX_EN
  localparam logic [6:0] HA = 7'b0001000;
`else
  localparam logic [6:0] HA = 7'b1111111;
`endif

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(8),
    .DEAD_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .dp       (dp),
    .lzb_en   (lzb_en),
    .an_n     (an_n),
    .seg_n    (seg_n),
    .dp_n     (dp_n),
    .slot_tick(slot_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_slot(input int d, input logic [6:0] s, input logic dpn);
    exp_t e;
    e.an  = ~(4'b0001 << d);
    e.seg = s;
    e.dp  = dpn;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic z);
    value  = v;
    dp     = d;
    lzb_en = z;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  // Stimulus
  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    value  = '0;
    dp     = '0;
    lzb_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_an_n", 32'(an_n), 32'hF);
    check("reset_seg_n", 32'(seg_n), 32'h7F);
    check("reset_dp_n", 32'(dp_n), 32'h1);
    check("reset_slot_tick", 32'(slot_tick), 32'h0);

    // Frame 0 shows zeros; frame 1 shows the load made during digit 1 of frame 0.
    for (int d = 0; d < 4; d++) push_slot(d, Z0, 1'b1);
    push_slot(0, S4, 1'b1);
    push_slot(1, S3, 1'b1);
    push_slot(2, S2, 1'b1);
    push_slot(3, S1, 1'b1);
    // Frame 2: load coincident with the boundary, lzb on, dp on digit 1.
    push_slot(0, Z0, 1'b1);
    push_slot(1, S5, 1'b0);
    push_slot(2, BL, 1'b1);
    push_slot(3, BL, 1'b1);
    // Frame 3: code A on digit 0, no blanking.
    push_slot(0, HA, 1'b1);
    for (int d = 1; d < 4; d++) push_slot(d, Z0, 1'b1);
    // Frame 4: 0305 with lzb; interior zero stays lit.
    push_slot(0, S5, 1'b1);
    push_slot(1, Z0, 1'b1);
    push_slot(2, S3, 1'b1);
    push_slot(3, BL, 1'b1);
    // Frame 5: all zero with lzb.
    push_slot(0, Z0, 1'b1);
    for (int d = 1; d < 4; d++) push_slot(d, BL, 1'b1);
    // Frame 6: same display, cut short by reset during digit 2.
    push_slot(0, Z0, 1'b1);
    push_slot(1, BL, 1'b1);
    push_slot(2, BL, 1'b1);

    #2 rst_n = 1'b1;
    n = 0;
    while (!slot_tick && n < 20) step();
    check("first_tick_edges", 32'(n), 32'd8);
    step();
    check("tick_one_cycle", 32'(slot_tick), 32'h0);

    run_to(11);
    do_load(16'h1234, 4'b0000, 1'b0);       // sampled at edge 12, digit 1 slot
    run_to(63);
    do_load(16'h0050, 4'b0010, 1'b1);       // sampled at edge 64, frame boundary
    run_to(79);
    do_load(16'h000A, 4'b0000, 1'b0);
    run_to(99);
    do_load(16'h9999, 4'b0000, 1'b0);
    run_to(109);
    do_load(16'h0305, 4'b0000, 1'b1);       // overrides the earlier load
    run_to(139);
    do_load(16'h0000, 4'b0000, 1'b1);
    run_to(213);                            // mid-slot of digit 2 in frame 6
    #2 rst_n = 1'b0;
    #1;
    check("midreset_an_n", 32'(an_n), 32'hF);
    check("midreset_seg_n", 32'(seg_n), 32'h7F);
    check("midreset_dp_n", 32'(dp_n), 32'h1);
    check("midreset_slot_tick", 32'(slot_tick), 32'h0);
    check("midreset_leftover", 32'(exp_q.size()), 32'd0);

    for (int d = 0; d < 4; d++) push_slot(d, Z0, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    while (!slot_tick && n < 20) step();
    check("restart_tick_edges", 32'(n), 32'd8);
    run_to(34);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor
  initial begin
    exp_t cur;
    logic active = 1'b0;
    logic have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else if (an_n != 4'hF) begin
        if (!active) begin
          active = 1'b1;
          if (exp_q.size() == 0) begin
            have = 1'b0;
            checks++;
            errors++;
            $display("FAIL unexpected_slot actual an_n=%b required no lit slot", an_n);
          end else begin
            have = 1'b1;
            cur  = exp_q.pop_front();
          end
        end
        if (have) begin
          check("slot_an_n", 32'(an_n), 32'(cur.an));
          check("slot_seg_n", 32'(seg_n), 32'(cur.seg));
          check("slot_dp_n", 32'(dp_n), 32'(cur.dp));
        end
      end else begin
        active = 1'b0;
        check("dead_dp_n", 32'(dp_n), 32'h1);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
